fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding + load-use hazard controller for the in-order RISC-V pipe. Keeps its own

---
 rtl/fwd_hazard_unit.sv | 97 +++++++++
 tb/tb_fwd_hazard_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - bypass select and load-use stall controller for the in-order pipe
module fwd_hazard_unit #(
  parameter  int REG_AW     = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int NUM_STAGES = 2,
  parameter  int LOAD_STAGE = 1,
  localparam int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_wen,
  input  logic                      id_is_load,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      flush,
  input  logic                      hold,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_id,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_x,
  output logic                      load_use_stall,
  output logic [31:0]               stall_count
);

  // Shadow of the destinations in flight; index 0 is the X stage (youngest).
  // An entry is only marked valid when it really writes a non-zero register,
  // so x0 never produces a bypass.
  logic [NUM_STAGES-1:0]             ent_v;
  logic [NUM_STAGES-1:0]             ent_ld;
  logic [NUM_STAGES-1:0][REG_AW-1:0] ent_rd;

  // Per-operand source index and "this operand needs a value" qualifier.
  logic [NUM_SRC-1:0][REG_AW-1:0] src;
  logic [NUM_SRC-1:0]             src_live;

  // Per-operand flag: the youngest producer is a load whose data is not
  // available yet at that stage.
  logic [NUM_SRC-1:0] ld_block;

  // ID instruction does not enter X this cycle.
  logic bubble;

  // New X-stage entry formed from the ID instruction.
  logic id_writes;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src[gi]      = id_rs[gi*REG_AW +: REG_AW];
      assign src_live[gi] = id_valid & id_rs_used[gi] & (|src[gi]);
    end
  endgenerate

  // Youngest-wins match: scan oldest to youngest so the youngest hit lands last.
  always_comb begin
    fwd_sel_id = '0;
    ld_block   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (src_live[i] && ent_v[k] && (ent_rd[k] == src[i])) begin
          fwd_sel_id[i*SELW +: SELW] = SELW'(k + 1);
          ld_block[i]                = ent_ld[k] && (k < LOAD_STAGE);
        end
      end
    end
  end

  // A flush kills the ID instruction, so it can never be stalled on.
  assign load_use_stall = id_valid & ~flush & (|ld_block);
  assign bubble         = flush | load_use_stall | ~id_valid;
  assign id_writes      = id_wen & (|id_rd);

  // Pipeline shadow, X-stage select copy and stall counter; hold freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_v       <= '0;
      ent_ld      <= '0;
      ent_rd      <= '0;
      fwd_sel_x   <= '0;
      stall_count <= '0;
    end else if (!hold) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        ent_v[k]  <= ent_v[k-1];
        ent_ld[k] <= ent_ld[k-1];
        ent_rd[k] <= ent_rd[k-1];
      end
      ent_v[0]  <= ~bubble & id_writes;
      ent_ld[0] <= id_is_load;
      ent_rd[0] <= id_rd;
      fwd_sel_x <= bubble ? '0 : fwd_sel_id;
      if (load_use_stall && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed vectors plus randomized reference-model check
module tb_fwd_hazard_unit;

  localparam int NS = 2;
  localparam int LS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_wen, id_is_load;
  logic [4:0]  id_rd;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        flush, hold;
  logic [3:0]  fwd_sel_id, fwd_sel_x;
  logic        load_use_stall;
  logic [31:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wen(id_wen), .id_is_load(id_is_load),
    .id_rd(id_rd), .id_rs(id_rs), .id_rs_used(id_rs_used), .flush(flush), .hold(hold),
    .fwd_sel_id(fwd_sel_id), .fwd_sel_x(fwd_sel_x), .load_use_stall(load_use_stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, v, wen, ld;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  used;
    logic        flush, hold;
    logic [3:0]  e_sel;
    logic        e_stall;
    logic [3:0]  e_x;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sat[$];

  function automatic vec_t mk(logic r, logic v, logic w, logic l, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [1:0] u, logic f,
                              logic h, logic [3:0] es, logic est, logic [3:0] ex,
                              logic [31:0] ec);
    vec_t t;
    t.rst = r; t.v = v; t.wen = w; t.ld = l; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.used = u; t.flush = f; t.hold = h; t.e_sel = es; t.e_stall = est; t.e_x = ex;
    t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; id_valid = t.v; id_wen = t.wen; id_is_load = t.ld; id_rd = t.rd;
    id_rs = {t.rs2, t.rs1}; id_rs_used = t.used; flush = t.flush; hold = t.hold;
  endtask

  // One row per cycle: drive after posedge, check at negedge, advance.
  task automatic run_rows(input string tag, input vec_t rows[$]);
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      chk($sformatf("%s[%0d].sel_id", tag, i), {28'd0, fwd_sel_id}, {28'd0, rows[i].e_sel});
      chk($sformatf("%s[%0d].stall", tag, i), {31'd0, load_use_stall}, {31'd0, rows[i].e_stall});
      chk($sformatf("%s[%0d].sel_x", tag, i), {28'd0, fwd_sel_x}, {28'd0, rows[i].e_x});
      chk($sformatf("%s[%0d].count", tag, i), stall_count, rows[i].e_cnt);
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: list of what entered X on each advancing cycle, youngest first.
  typedef struct {
    bit       w;
    bit [4:0] rd;
    bit       ld;
  } ent_t;

  ent_t    pipe[$];
  bit [3:0] m_x;
  longint  m_cnt;

  task automatic model_clear();
    ent_t e;
    e.w = 0; e.rd = 0; e.ld = 0;
    pipe.delete();
    for (int k = 0; k < NS; k++) pipe.push_back(e);
    m_x   = 0;
    m_cnt = 0;
  endtask

  function automatic void lookup(input bit v, input bit used, input bit [4:0] rs,
                                 output bit [1:0] sel, output bit ld_young);
    bit found;
    sel = 0; ld_young = 0; found = 0;
    if (v && used && rs != 0) begin
      for (int k = 0; k < pipe.size(); k++) begin
        if (!found && pipe[k].w && pipe[k].rd == rs) begin
          found    = 1;
          sel      = 2'(k + 1);
          ld_young = pipe[k].ld && (k < LS);
        end
      end
    end
  endfunction

  task automatic random_run(input int cycles);
    bit [1:0] s1, s2;
    bit       l1, l2, e_stall, bub;
    ent_t     e;
    for (int i = 0; i < cycles; i++) begin
      rst        = (i == 0) || ($urandom_range(0, 49) == 0);
      id_valid   = ($urandom_range(0, 99) < 85);
      id_wen     = ($urandom_range(0, 99) < 70);
      id_is_load = ($urandom_range(0, 99) < 30);
      id_rd      = 5'($urandom_range(0, 3));
      id_rs      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 99) < 10);
      hold       = ($urandom_range(0, 99) < 15);
      @(negedge clk);
      lookup(id_valid, id_rs_used[0], id_rs[4:0], s1, l1);
      lookup(id_valid, id_rs_used[1], id_rs[9:5], s2, l2);
      e_stall = id_valid && !flush && (l1 || l2);
      chk($sformatf("rnd[%0d].sel_id", i), {28'd0, fwd_sel_id}, {28'd0, s2, s1});
      chk($sformatf("rnd[%0d].stall", i), {31'd0, load_use_stall}, {31'd0, e_stall});
      chk($sformatf("rnd[%0d].sel_x", i), {28'd0, fwd_sel_x}, {28'd0, m_x});
      chk($sformatf("rnd[%0d].count", i), stall_count, 32'(m_cnt));
      if (rst) begin
        model_clear();
      end else if (!hold) begin
        bub  = flush || e_stall || !id_valid;
        e.w  = !bub && id_wen && (id_rd != 0);
        e.rd = id_rd;
        e.ld = id_is_load;
        pipe.push_front(e);
        void'(pipe.pop_back());
        m_x = bub ? 4'd0 : {s2, s1};
        if (e_stall) m_cnt = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Directed sequence: each row is one cycle, expectations are outputs seen that cycle.
    //                rst v w l rd  rs1 rs2 used  f h   sel   st x     cnt
    tbl.push_back(mk(0, 1, 1, 0, 5, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 6, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 4'h2, 0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 4'h0, 0, 4'h2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 5, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 5, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5, 2'b10, 0, 0, 4'h4, 0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 7, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 7, 2'b10, 0, 0, 4'h4, 1, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 7, 2'b10, 0, 0, 4'h8, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h8, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8, 8, 2'b00, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 9, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 9, 0, 2'b01, 0, 1, 4'h1, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 9, 0, 2'b01, 0, 1, 4'h1, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 9, 0, 2'b01, 0, 1, 4'h1, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 9, 0, 2'b01, 0, 0, 4'h1, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 9, 0, 2'b01, 0, 0, 4'h2, 0, 4'h1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 10, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h2, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 10, 0, 2'b01, 0, 1, 4'h1, 1, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 10, 0, 2'b01, 0, 1, 4'h1, 1, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 10, 0, 2'b01, 0, 0, 4'h1, 1, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 10, 0, 2'b01, 0, 0, 4'h2, 0, 4'h0, 2));
    tbl.push_back(mk(0, 1, 1, 1, 11, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h2, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 11, 0, 2'b01, 1, 0, 4'h1, 0, 4'h0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 2));
    tbl.push_back(mk(0, 1, 1, 0, 12, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 12, 0, 2'b01, 0, 0, 4'h1, 0, 4'h0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 12, 0, 2'b01, 0, 0, 4'h0, 0, 4'h0, 0));

    // Saturation: counter starts one below the maximum.
    sat.push_back(mk(0, 1, 1, 1, 3, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 32'hFFFF_FFFE));
    sat.push_back(mk(0, 1, 0, 0, 0, 0, 3, 2'b10, 0, 0, 4'h4, 1, 4'h0, 32'hFFFF_FFFE));
    sat.push_back(mk(0, 1, 0, 0, 0, 0, 3, 2'b10, 0, 0, 4'h8, 0, 4'h0, 32'hFFFF_FFFF));
    sat.push_back(mk(0, 1, 1, 1, 3, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h8, 32'hFFFF_FFFF));
    sat.push_back(mk(0, 1, 0, 0, 0, 0, 3, 2'b10, 0, 0, 4'h4, 1, 4'h0, 32'hFFFF_FFFF));
    sat.push_back(mk(0, 1, 0, 0, 0, 0, 3, 2'b10, 0, 0, 4'h8, 0, 4'h0, 32'hFFFF_FFFF));

    drive(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset.sel_id", {28'd0, fwd_sel_id}, 32'd0);
    chk("reset.stall", {31'd0, load_use_stall}, 32'd0);
    chk("reset.sel_x", {28'd0, fwd_sel_x}, 32'd0);
    chk("reset.count", stall_count, 32'd0);
    @(posedge clk);
    #1;

    run_rows("dir", tbl);

    model_clear();
    random_run(400);

    drive(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 0, 4'h0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    force dut.stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count;
    run_rows("sat", sat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
